// File: rtl/riscv_pkg.sv
// Shared RV32I-subset decode constants: opcodes, ALU/result/immediate selects
// and the packed control bundle carried from decode into execute.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [2:0] funct3;
        logic [3:0] alu_ctrl;
        logic       alu_src;
    } ctrl_t;

    // sub only exists for R-type; callers pass sub_sel = 0 for the I-ALU group
    function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic sub_sel);
        case (funct3)
            3'b000:  alu_decode = sub_sel ? ALU_SUB : ALU_ADD;
            3'b111:  alu_decode = ALU_AND;
            3'b110:  alu_decode = ALU_OR;
            3'b100:  alu_decode = ALU_XOR;
            3'b010:  alu_decode = ALU_SLT;
            3'b001:  alu_decode = ALU_SLL;
            3'b101:  alu_decode = ALU_SRL;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // instr_hi is Instr[31:7]; index n here is instruction bit n+7
    function automatic logic [31:0] imm_ext(input logic [24:0] instr_hi, input imm_src_e src);
        case (src)
            IMM_S:   imm_ext = {{21{instr_hi[24]}}, instr_hi[23:18], instr_hi[4:0]};
            IMM_B:   imm_ext = {{20{instr_hi[24]}}, instr_hi[0], instr_hi[23:18],
                                instr_hi[4:1], 1'b0};
            IMM_J:   imm_ext = {{12{instr_hi[24]}}, instr_hi[12:5], instr_hi[13],
                                instr_hi[23:14], 1'b0};
            IMM_U:   imm_ext = {instr_hi[24:5], 12'h000};
            default: imm_ext = {{21{instr_hi[24]}}, instr_hi[23:13]};
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 hard-wired to zero.
module reg_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    output logic [31:0] data1,
    output logic [31:0] data2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];
    logic        wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data1 = regs[addr1];
        data2 = regs[addr2];
        if (addr1 == '0)                        data1 = '0;
        else if (wr_live && wr_addr == addr1)   data1 = wr_data;
        if (addr2 == '0)                        data2 = '0;
        else if (wr_live && wr_addr == addr2)   data2 = wr_data;
    end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: combinational decode/immediate generation, register-file read
// and the D->E pipeline register with flush.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Flush_E,
    input  logic [31:0] Instr_D,
    input  logic [31:0] PC_D,
    input  logic [31:0] PCPlus4_D,
    input  logic        RegWrite_W,
    input  logic [4:0]  Rd_W,
    input  logic [31:0] Result_W,
    output logic [4:0]  Rs1_D,
    output logic [4:0]  Rs2_D,
    output logic        RegWrite_E,
    output logic [1:0]  ResultSrc_E,
    output logic        MemWrite_E,
    output logic        Jump_E,
    output logic        Jalr_E,
    output logic        Branch_E,
    output logic [2:0]  Funct3_E,
    output logic [3:0]  ALUControl_E,
    output logic        ALUSrc_E,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [31:0] PC_E,
    output logic [31:0] PCPlus4_E,
    output logic [4:0]  Rd_E,
    output logic [4:0]  Rs1_E,
    output logic [4:0]  Rs2_E
);

    ctrl_t       ctrl_d, ctrl_e;
    imm_src_e    imm_src;
    logic [4:0]  rs1_addr;
    logic [31:0] rd1_d, rd2_d, imm_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    assign opcode = Instr_D[6:0];
    assign funct3 = Instr_D[14:12];
    assign Rs1_D  = Instr_D[19:15];
    assign Rs2_D  = Instr_D[24:20];

    // lui reads x0 so the ALU computes 0 + imm without a dedicated path
    assign rs1_addr = (opcode == OP_LUI) ? 5'd0 : Instr_D[19:15];

    always_comb begin
        ctrl_d  = '0;
        imm_src = IMM_I;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.funct3    = funct3;
                ctrl_d.alu_ctrl  = alu_decode(funct3, Instr_D[30]);
            end
            OP_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.funct3    = funct3;
                ctrl_d.alu_ctrl  = alu_decode(funct3, 1'b0);
                ctrl_d.alu_src   = 1'b1;
            end
            OP_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_MEM;
                ctrl_d.funct3     = funct3;
                ctrl_d.alu_src    = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.funct3    = funct3;
                ctrl_d.alu_src   = 1'b1;
                imm_src          = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.funct3   = funct3;
                ctrl_d.alu_ctrl = ALU_SUB;
                imm_src         = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jump       = 1'b1;
                imm_src           = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.alu_src    = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src          = IMM_U;
            end
            default: ctrl_d = '0;
        endcase
    end

    assign imm_d = imm_ext(Instr_D[31:7], imm_src);

    reg_file u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr1   (rs1_addr),
        .addr2   (Instr_D[24:20]),
        .data1   (rd1_d),
        .data2   (rd2_d),
        .wr_en   (RegWrite_W),
        .wr_addr (Rd_W),
        .wr_data (Result_W)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || Flush_E) begin
            ctrl_e    <= '0;
            RD1_E     <= '0;
            RD2_E     <= '0;
            Imm_Ext_E <= '0;
            PC_E      <= '0;
            PCPlus4_E <= '0;
            Rd_E      <= '0;
            Rs1_E     <= '0;
            Rs2_E     <= '0;
        end else begin
            ctrl_e    <= ctrl_d;
            RD1_E     <= rd1_d;
            RD2_E     <= rd2_d;
            Imm_Ext_E <= imm_d;
            PC_E      <= PC_D;
            PCPlus4_E <= PCPlus4_D;
            Rd_E      <= Instr_D[11:7];
            Rs1_E     <= rs1_addr;
            Rs2_E     <= Instr_D[24:20];
        end
    end

    assign RegWrite_E   = ctrl_e.reg_write;
    assign ResultSrc_E  = ctrl_e.result_src;
    assign MemWrite_E   = ctrl_e.mem_write;
    assign Jump_E       = ctrl_e.jump;
    assign Jalr_E       = ctrl_e.jalr;
    assign Branch_E     = ctrl_e.branch;
    assign Funct3_E     = ctrl_e.funct3;
    assign ALUControl_E = ctrl_e.alu_ctrl;
    assign ALUSrc_E     = ctrl_e.alu_src;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed scenarios plus random instruction mix, each
// instruction built from a mnemonic and checked against a register-array model.
module tb_decode_cycle;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, Flush_E, RegWrite_W;
    logic [31:0] Instr_D, PC_D, PCPlus4_D, Result_W;
    logic [4:0]  Rd_W, Rs1_D, Rs2_D;
    logic        RegWrite_E, MemWrite_E, Jump_E, Jalr_E, Branch_E, ALUSrc_E;
    logic [1:0]  ResultSrc_E;
    logic [2:0]  Funct3_E;
    logic [3:0]  ALUControl_E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlus4_E;
    logic [4:0]  Rd_E, Rs1_E, Rs2_E;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst_n(rst_n), .Flush_E(Flush_E), .Instr_D(Instr_D), .PC_D(PC_D),
        .PCPlus4_D(PCPlus4_D), .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E),
        .MemWrite_E(MemWrite_E), .Jump_E(Jump_E), .Jalr_E(Jalr_E), .Branch_E(Branch_E),
        .Funct3_E(Funct3_E), .ALUControl_E(ALUControl_E), .ALUSrc_E(ALUSrc_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PC_E(PC_E),
        .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E)
    );

    typedef enum int {C_R, C_I, C_SH, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_BAD, C_ZERO} cls_e;
    typedef struct { string nm; cls_e cls; logic [2:0] f3; logic f7; logic [3:0] alu; } op_t;
    typedef struct packed {
        logic rw; logic [1:0] rsrc; logic mw, j, jr, br; logic [2:0] f3; logic [3:0] alu;
        logic asrc; logic [31:0] rd1, rd2, imm, pc, pc4; logic [4:0] rd, rs1, rs2;
    } exp_t;

    op_t         ops[$];
    logic [31:0] model_regs [32];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("RegWrite_E", RegWrite_E, e.rw);
        check("ResultSrc_E", ResultSrc_E, e.rsrc);
        check("MemWrite_E", MemWrite_E, e.mw);
        check("Jump_E", Jump_E, e.j);
        check("Jalr_E", Jalr_E, e.jr);
        check("Branch_E", Branch_E, e.br);
        check("Funct3_E", Funct3_E, e.f3);
        check("ALUControl_E", ALUControl_E, e.alu);
        check("ALUSrc_E", ALUSrc_E, e.asrc);
        check("RD1_E", RD1_E, e.rd1);
        check("RD2_E", RD2_E, e.rd2);
        check("Imm_Ext_E", Imm_Ext_E, e.imm);
        check("PC_E", PC_E, e.pc);
        check("PCPlus4_E", PCPlus4_E, e.pc4);
        check("Rd_E", Rd_E, e.rd);
        check("Rs1_E", Rs1_E, e.rs1);
        check("Rs2_E", Rs2_E, e.rs2);
    endtask

    function automatic int find_op(input string nm);
        foreach (ops[i]) if (ops[i].nm == nm) return i;
        return 0;
    endfunction

    function automatic int rand_imm(input cls_e c);
        case (c)
            C_I, C_LW, C_SW, C_JALR: return int'($urandom_range(0, 4095)) - 2048;
            C_SH:  return int'($urandom_range(0, 31));
            C_BR:  return (int'($urandom_range(0, 4095)) - 2048) * 2;
            C_JAL: return (int'($urandom_range(0, 1048575)) - 524288) * 2;
            C_LUI: return int'($urandom & 32'hFFFF_F000);
            default: return 0;
        endcase
    endfunction

    // Builds the instruction word from a mnemonic and states the expected
    // decode; register data and pass-through fields are filled in by step().
    task automatic gen(input int k, input logic [4:0] rd, rs1, rs2, input int imm,
                       output logic [31:0] instr, output exp_t e);
        op_t         o = ops[k];
        logic [31:0] iv = imm;
        logic [31:0] r = $urandom;
        logic [6:0]  bad_ops [4] = '{7'b0001111, 7'b1110011, 7'b0010111, 7'b0000000};
        e = '0;
        e.imm = iv;
        case (o.cls)
            C_R:    begin instr = {1'b0, o.f7, 5'b0, rs2, rs1, o.f3, rd, 7'b0110011};
                          e.rw = 1; e.f3 = o.f3; e.alu = o.alu;
                          e.imm = {{20{instr[31]}}, instr[31:20]}; end
            C_I:    begin instr = {iv[11:0], rs1, o.f3, rd, 7'b0010011};
                          e.rw = 1; e.f3 = o.f3; e.alu = o.alu; e.asrc = 1; end
            C_SH:   begin instr = {7'b0, iv[4:0], rs1, o.f3, rd, 7'b0010011};
                          e.rw = 1; e.f3 = o.f3; e.alu = o.alu; e.asrc = 1; end
            C_LW:   begin instr = {iv[11:0], rs1, 3'b010, rd, 7'b0000011};
                          e.rw = 1; e.rsrc = 2'b01; e.f3 = 3'b010; e.asrc = 1; end
            C_SW:   begin instr = {iv[11:5], rs2, rs1, 3'b010, iv[4:0], 7'b0100011};
                          e.mw = 1; e.f3 = 3'b010; e.asrc = 1; end
            C_BR:   begin instr = {iv[12], iv[10:5], rs2, rs1, o.f3, iv[4:1], iv[11], 7'b1100011};
                          e.br = 1; e.f3 = o.f3; e.alu = 4'd1; end
            C_JAL:  begin instr = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
                          e.rw = 1; e.rsrc = 2'b10; e.j = 1; end
            C_JALR: begin instr = {iv[11:0], rs1, 3'b000, rd, 7'b1100111};
                          e.rw = 1; e.rsrc = 2'b10; e.jr = 1; e.asrc = 1; end
            C_LUI:  begin instr = {iv[31:12], rd, 7'b0110111};
                          e.rw = 1; e.asrc = 1; end
            C_BAD:  begin instr = {r[31:7], bad_ops[$urandom_range(0, 3)]};
                          if (instr == 32'h0) instr = 32'h0000_0080;
                          e.imm = {{20{instr[31]}}, instr[31:20]}; end
            default: begin instr = 32'h0; e.imm = 32'h0; end
        endcase
        e.rs1 = (o.cls == C_LUI) ? 5'd0 : instr[19:15];
    endtask

    // One D-stage cycle: drive, update the model, clock, compare every *_E.
    task automatic step(input logic [31:0] instr, input exp_t ei, input logic [31:0] pc,
                        input bit flush, input bit we, input logic [4:0] wrd,
                        input logic [31:0] wres);
        exp_t e = ei;
        Instr_D = instr; PC_D = pc; PCPlus4_D = pc + 32'd4; Flush_E = flush;
        RegWrite_W = we; Rd_W = wrd; Result_W = wres;
        #1;
        check("Rs1_D", Rs1_D, instr[19:15]);
        check("Rs2_D", Rs2_D, instr[24:20]);
        if (we && wrd != 0) model_regs[wrd] = wres;
        e.rd1 = model_regs[e.rs1];
        e.rs2 = instr[24:20];
        e.rd2 = model_regs[e.rs2];
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        e.rd  = instr[11:7];
        if (flush) e = '0;
        @(posedge clk);
        #1;
        check_all(e);
    endtask

    task automatic run_op(input string nm, input logic [4:0] rd, rs1, rs2, input int imm,
                          input logic [31:0] pc, input bit flush, input bit we,
                          input logic [4:0] wrd, input logic [31:0] wres);
        logic [31:0] instr;
        exp_t        e;
        gen(find_op(nm), rd, rs1, rs2, imm, instr, e);
        step(instr, e, pc, flush, we, wrd, wres);
    endtask

    initial begin
        ops = '{
            '{"add", C_R, 3'd0, 1'b0, ALU_ADD}, '{"sub", C_R, 3'd0, 1'b1, ALU_SUB},
            '{"and", C_R, 3'd7, 1'b0, ALU_AND}, '{"or", C_R, 3'd6, 1'b0, ALU_OR},
            '{"xor", C_R, 3'd4, 1'b0, ALU_XOR}, '{"slt", C_R, 3'd2, 1'b0, ALU_SLT},
            '{"sll", C_R, 3'd1, 1'b0, ALU_SLL}, '{"srl", C_R, 3'd5, 1'b0, ALU_SRL},
            '{"addi", C_I, 3'd0, 1'b0, ALU_ADD}, '{"andi", C_I, 3'd7, 1'b0, ALU_AND},
            '{"ori", C_I, 3'd6, 1'b0, ALU_OR}, '{"xori", C_I, 3'd4, 1'b0, ALU_XOR},
            '{"slti", C_I, 3'd2, 1'b0, ALU_SLT}, '{"slli", C_SH, 3'd1, 1'b0, ALU_SLL},
            '{"srli", C_SH, 3'd5, 1'b0, ALU_SRL}, '{"lw", C_LW, 3'd2, 1'b0, ALU_ADD},
            '{"sw", C_SW, 3'd2, 1'b0, ALU_ADD}, '{"beq", C_BR, 3'd0, 1'b0, ALU_SUB},
            '{"bne", C_BR, 3'd1, 1'b0, ALU_SUB}, '{"blt", C_BR, 3'd4, 1'b0, ALU_SUB},
            '{"bge", C_BR, 3'd5, 1'b0, ALU_SUB}, '{"jal", C_JAL, 3'd0, 1'b0, ALU_ADD},
            '{"jalr", C_JALR, 3'd0, 1'b0, ALU_ADD}, '{"lui", C_LUI, 3'd0, 1'b0, ALU_ADD},
            '{"bad", C_BAD, 3'd0, 1'b0, ALU_ADD}, '{"zero", C_ZERO, 3'd0, 1'b0, ALU_ADD}
        };
        foreach (model_regs[i]) model_regs[i] = '0;

        rst_n = 1'b0; Flush_E = 0; Instr_D = 32'h0000_0033; PC_D = 32'h10; PCPlus4_D = 32'h14;
        RegWrite_W = 0; Rd_W = 0; Result_W = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all('0);
        @(negedge clk);
        rst_n = 1'b1;

        // write x5, then add x6,x5,x5
        run_op("zero", 0, 0, 0, 0, 32'h0, 0, 1, 5'd5, 32'h0000_1234);
        run_op("add", 5'd6, 5'd5, 5'd5, 0, 32'h100, 0, 0, 0, 0);
        check("add_rd1", RD1_E, 32'h1234);
        check("add_rd2", RD2_E, 32'h1234);
        check("add_rw", RegWrite_E, 1'b1);
        check("add_alu", ALUControl_E, ALU_ADD);
        check("add_rd", Rd_E, 5'd6);

        // same-cycle writeback feeding a store
        run_op("sw", 0, 5'd2, 5'd7, -4, 32'h104, 0, 1, 5'd7, 32'hDEAD_BEEF);
        check("sw_rd2", RD2_E, 32'hDEAD_BEEF);
        check("sw_imm", Imm_Ext_E, 32'hFFFF_FFFC);
        check("sw_mw", MemWrite_E, 1'b1);
        check("sw_rw", RegWrite_E, 1'b0);

        // x0 stays zero
        run_op("zero", 0, 0, 0, 0, 32'h0, 0, 1, 5'd0, 32'd5);
        run_op("add", 5'd1, 5'd0, 5'd0, 0, 32'h108, 0, 1, 5'd0, 32'd5);
        check("x0_rd1", RD1_E, 32'h0);

        run_op("jal", 5'd1, 0, 0, -8, 32'h40, 0, 0, 0, 0);
        check("jal_j", Jump_E, 1'b1);
        check("jal_imm", Imm_Ext_E, 32'hFFFF_FFF8);
        check("jal_pc", PC_E, 32'h40);
        check("jal_pc4", PCPlus4_E, 32'h44);
        check("jal_rsrc", ResultSrc_E, 2'b10);

        // flush wins over a beq, but the writeback alongside it still lands
        run_op("beq", 0, 5'd5, 5'd6, 16, 32'h48, 1, 1, 5'd9, 32'h0000_0999);
        run_op("zero", 0, 0, 0, 0, 32'h4C, 0, 0, 0, 0);
        run_op("lui", 5'd3, 5'd9, 0, 32'hABCD_E000, 32'h50, 0, 0, 0, 0);
        run_op("addi", 5'd4, 5'd9, 0, -1, 32'h54, 0, 0, 0, 0);
        check("flush_wb", RD1_E, 32'h0000_0999);

        for (int n = 0; n < 400; n++) begin
            int          k = $urandom_range(0, ops.size() - 1);
            logic [31:0] instr;
            exp_t        e;
            gen(k, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), rand_imm(ops[k].cls), instr, e);
            step(instr, e, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        // async reset mid-stream discards a pending writeback
        run_op("add", 5'd6, 5'd5, 5'd5, 0, 32'h200, 0, 1, 5'd5, 32'h0000_5555);
        #2;
        RegWrite_W = 1; Rd_W = 5'd5; Result_W = 32'hFFFF_0000;
        rst_n = 1'b0;
        #1;
        check_all('0);
        foreach (model_regs[i]) model_regs[i] = '0;
        @(negedge clk);
        RegWrite_W = 0;
        rst_n = 1'b1;
        run_op("add", 5'd6, 5'd5, 5'd5, 0, 32'h300, 0, 0, 0, 0);
        check("rst_x5", RD1_E, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Flush_E, input, 1, from the hazard unit; clears the D->E register.
REQ-004 SHALL have ports Instr_D / PC_D / PCPlus4_D, input, 32 each, from the F->D register.
REQ-005 SHALL have ports RegWrite_W (1), Rd_W (5) and Result_W (32), input; this is the writeback port.
REQ-006 SHALL have ports Rs1_D and Rs2_D, output, 5 each, combinational Instr_D[19:15] and [24:20], for the hazard unit.
REQ-007 SHALL have registered control outputs: RegWrite_E (1), ResultSrc_E (2), MemWrite_E (1), Jump_E (1), Jalr_E (1), Branch_E (1), Funct3_E (3), ALUControl_E (4), ALUSrc_E (1).
REQ-008 SHALL have registered data outputs: RD1_E, RD2_E, Imm_Ext_E, PC_E and PCPlus4_E (32 each), plus Rd_E, Rs1_E and Rs2_E (5 each).

Function
REQ-009 SHALL decode this subset:
- R-type: add, sub, and, or, xor, slt, sll, srl
- I-ALU: addi, andi, ori, xori, slti, slli, srli
- lw, sw
- beq, bne, blt, bge
- jal, jalr, lui
REQ-010 SHALL set ResultSrc as follows: 00 ALU, 01 memory, 10 PC+4 (for jal/jalr).
REQ-011 SHALL use the ALUControl encoding from the package; sub is selected by funct7[5] for R-type only, never for addi.
REQ-012 SHALL produce immediates for types I, S, B, J and U, each sign-extended to 32 bits; B and J have bit 0 = 0, U has [11:0] = 0.
REQ-013 SHALL implement lui as ALU add with Rs1 forced to x0 and ALUSrc = 1.
REQ-014 SHALL treat any unsupported opcode, and Instr_D = 0, as a bubble: all control bits 0, with data fields passed through.
REQ-015 SHALL provide a register file of 32 x 32 bits: x0 reads 0 and is never written; writes occur on the rising edge when RegWrite_W = 1 and Rd_W != 0.
REQ-016 SHALL provide a write-through bypass: when RegWrite_W = 1, Rd_W != 0 and Rd_W == Rs1_D (or Rs2_D), the read data SHALL equal Result_W in the same cycle.
REQ-017 SHALL latch all decoded fields into the D->E register on every rising edge; latency is 1 cycle from Instr_D to the *_E outputs.
REQ-018 SHALL, when Flush_E = 1 at a rising edge, load every *_E output with 0; Flush_E takes priority over new data.
REQ-019 SHALL allow a writeback and a flush in the same cycle, in which case the register-file write SHALL still take effect.
REQ-020 SHALL have no stall input; D-stage stalls are handled by holding Instr_D upstream and flushing E.

Reset
REQ-021 SHALL clear all D->E register outputs to 0 while rst_n = 0, independent of clk.
REQ-022 SHALL clear all 32 register-file entries to 0 on reset.
REQ-023 SHALL, on reset assertion mid-operation, discard any in-flight writeback; on the first edge after release, decode proceeds normally.

Structure
REQ-024 SHALL place the following in the shared package riscv_pkg: opcode constants, ALUControl encodings, ResultSrc encodings and ImmSrc encodings.
REQ-025 SHALL implement the register file as the sub-module reg_file (two combinational read ports, one synchronous write port, bypass inside).
REQ-026 SHALL keep decode and immediate generation combinational inside decode_cycle.

Verification
REQ-027 SHALL cover: write x5 = 0x0000_1234 via W, then Instr_D = add x6,x5,x5 -> next cycle RD1_E = RD2_E = 0x1234, RegWrite_E = 1, ALUControl_E = add, Rd_E = 6.
REQ-028 SHALL cover: same-cycle RegWrite_W (x7 = 0xDEAD_BEEF) with Instr_D = sw x7,-4(x2) -> RD2_E = 0xDEADBEEF, Imm_Ext_E = 0xFFFF_FFFC, MemWrite_E = 1, RegWrite_E = 0.
REQ-029 SHALL cover: a write to x0 with Result_W = 5, then a read of x0 -> RD1_E = 0.
REQ-030 SHALL cover: jal x1,-8 at PC_D = 0x40 -> Jump_E = 1, Imm_Ext_E = 0xFFFF_FFF8, PC_E = 0x40, PCPlus4_E = 0x44, ResultSrc_E = 10.
REQ-031 SHALL cover: beq with Flush_E = 1 at the edge -> all *_E = 0; and Instr_D = 0x0000_0000 -> all control outputs = 0.
REQ-032 SHALL cover: rst_n asserted mid-stream, asynchronously -> all *_E outputs = 0 immediately, and a subsequent read of x5 returns 0.
